// File: rtl/coef_dpram_ctrl.sv
// ---------------------------------------------------------------------------
// coef_dpram_ctrl
//
// True dual-port coefficient memory for the Kyber NTT datapath, with:
//   - selectable read latency (RD_LAT = 1 or 2) and read-during-write mode
//   - per-port enables and read-valid tracking
//   - deterministic write-collision arbitration (port A wins) with a flag
//   - a clear engine that zeroes the array after reset or on request
//
// Optional build macro: COEF_DPRAM_PARITY_EN
//   Defined   : each word carries an even-parity bit. Reads check the
//               parity and pulse par_err_a_o / par_err_b_o, aligned with the
//               port's valid. Read data is delivered unchanged.
//   Undefined : the array is exactly DATA_W bits wide and no par_err ports.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high
//   clr_start_i    one-cycle request to zero the array (honoured in IDLE)
//   busy_o         high while the clear engine runs; port accesses ignored
//   en_a_i/we_a_i  port A enable / write enable (write qualified by enable)
//   addr_a_i       port A address
//   data_a_i       port A write data
//   q_a_o          port A read data
//   q_a_valid_o    q_a_o holds the result of an access issued RD_LAT earlier
//   *_b_*          same as port A, for port B
//   par_err_a_o/par_err_b_o  parity-mismatch pulses (parity build only)
//   collision_o    pulse: both ports wrote the same address in one cycle
// ---------------------------------------------------------------------------
module coef_dpram_ctrl #(
    parameter int DATA_W         = 12,
    parameter int ADDR_W         = 9,
    parameter int DEPTH          = 512,
    parameter int RD_LAT         = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_start_i,
    output logic              busy_o,
    input  logic              en_a_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [DATA_W-1:0] data_a_i,
    output logic [DATA_W-1:0] q_a_o,
    output logic              q_a_valid_o,
    input  logic              en_b_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [DATA_W-1:0] data_b_i,
    output logic [DATA_W-1:0] q_b_o,
    output logic              q_b_valid_o,
`ifdef COEF_DPRAM_PARITY_EN
    output logic              par_err_a_o,
    output logic              par_err_b_o,
`endif
    output logic              collision_o
);

`ifdef COEF_DPRAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic              WR_FIRST  = (RDW_MODE == 0);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    // -----------------------------------------------------------------------
    // Clear-engine FSM
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              busy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start_i) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        case (state_q)
            S_CLEAR: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign busy_o = busy;

    // -----------------------------------------------------------------------
    // Port qualification and write arbitration
    // -----------------------------------------------------------------------
    logic acc_a, acc_b;
    logic in_a, in_b;
    logic wr_a, wr_b;
    logic coll_hit;

    assign acc_a = ~busy & en_a_i;
    assign acc_b = ~busy & en_b_i;
    assign in_a  = ({1'b0, addr_a_i} < DEPTH_EXT);
    assign in_b  = ({1'b0, addr_b_i} < DEPTH_EXT);

    // Collision is flagged on the attempted writes; port A always wins.
    assign coll_hit = acc_a & acc_b & we_a_i & we_b_i & (addr_a_i == addr_b_i);
    assign wr_a     = acc_a & we_a_i & in_a;
    assign wr_b     = acc_b & we_b_i & in_b & ~coll_hit;

    logic [WORD_W-1:0] wword_a, wword_b;

`ifdef COEF_DPRAM_PARITY_EN
    // Even parity: the stored word XORs to zero, so an all-zero word is clean.
    assign wword_a = {^data_a_i, data_a_i};
    assign wword_b = {^data_b_i, data_b_i};
`else
    assign wword_a = data_a_i;
    assign wword_b = data_b_i;
`endif

    // -----------------------------------------------------------------------
    // Storage array
    // -----------------------------------------------------------------------
    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; zeroing
    // is the clear engine's job, one word per cycle.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (wr_b) begin
                mem[addr_b_i] <= wword_b;
            end
            if (wr_a) begin
                mem[addr_a_i] <= wword_a;
            end
        end
    end

    // Asynchronous array reads are the pre-write contents: this gives
    // read-first behaviour and the old value for a cross-port read.
    logic [WORD_W-1:0] rd_word_a, rd_word_b;

    assign rd_word_a = in_a ? mem[addr_a_i] : '0;
    assign rd_word_b = in_b ? mem[addr_b_i] : '0;

    // -----------------------------------------------------------------------
    // Read stage 1 (always present)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] q_a_d, q_b_d;
    logic [DATA_W-1:0] q_a_s1_q, q_b_s1_q;
    logic              vld_a_s1_q, vld_b_s1_q;
    logic              coll_s1_q;
    logic              perr_a_d, perr_b_d;
    logic              perr_a_s1_q, perr_b_s1_q;

    always_comb begin
        q_a_d = q_a_s1_q;
        q_b_d = q_b_s1_q;
        if (acc_a) begin
            if (!in_a) begin
                q_a_d = '0;
            end else if (we_a_i && WR_FIRST) begin
                q_a_d = data_a_i;
            end else begin
                q_a_d = rd_word_a[DATA_W-1:0];
            end
        end
        if (acc_b) begin
            if (!in_b) begin
                q_b_d = '0;
            end else if (we_b_i && WR_FIRST) begin
                q_b_d = data_b_i;
            end else begin
                q_b_d = rd_word_b[DATA_W-1:0];
            end
        end
    end

`ifdef COEF_DPRAM_PARITY_EN
    // Parity is only meaningful when the delivered data came from the array.
    assign perr_a_d = acc_a & in_a & ~(we_a_i & WR_FIRST) & (^rd_word_a);
    assign perr_b_d = acc_b & in_b & ~(we_b_i & WR_FIRST) & (^rd_word_b);
`else
    assign perr_a_d = 1'b0;
    assign perr_b_d = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_a_s1_q    <= '0;
            q_b_s1_q    <= '0;
            vld_a_s1_q  <= 1'b0;
            vld_b_s1_q  <= 1'b0;
            coll_s1_q   <= 1'b0;
            perr_a_s1_q <= 1'b0;
            perr_b_s1_q <= 1'b0;
        end else begin
            q_a_s1_q    <= q_a_d;
            q_b_s1_q    <= q_b_d;
            vld_a_s1_q  <= acc_a;
            vld_b_s1_q  <= acc_b;
            coll_s1_q   <= coll_hit;
            perr_a_s1_q <= perr_a_d;
            perr_b_s1_q <= perr_b_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional output register stage (RD_LAT = 2)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] q_a_out, q_b_out;
    logic              vld_a_out, vld_b_out;
    logic              coll_out;
    logic              perr_a_out, perr_b_out;

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] q_a_s2_q, q_b_s2_q;
        logic              vld_a_s2_q, vld_b_s2_q;
        logic              coll_s2_q;
        logic              perr_a_s2_q, perr_b_s2_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                q_a_s2_q    <= '0;
                q_b_s2_q    <= '0;
                vld_a_s2_q  <= 1'b0;
                vld_b_s2_q  <= 1'b0;
                coll_s2_q   <= 1'b0;
                perr_a_s2_q <= 1'b0;
                perr_b_s2_q <= 1'b0;
            end else begin
                // Data only advances with a valid access so q holds when idle.
                if (vld_a_s1_q) begin
                    q_a_s2_q <= q_a_s1_q;
                end
                if (vld_b_s1_q) begin
                    q_b_s2_q <= q_b_s1_q;
                end
                vld_a_s2_q  <= vld_a_s1_q;
                vld_b_s2_q  <= vld_b_s1_q;
                coll_s2_q   <= coll_s1_q;
                perr_a_s2_q <= perr_a_s1_q;
                perr_b_s2_q <= perr_b_s1_q;
            end
        end

        assign q_a_out    = q_a_s2_q;
        assign q_b_out    = q_b_s2_q;
        assign vld_a_out  = vld_a_s2_q;
        assign vld_b_out  = vld_b_s2_q;
        assign coll_out   = coll_s2_q;
        assign perr_a_out = perr_a_s2_q;
        assign perr_b_out = perr_b_s2_q;
    end else begin : g_lat1
        assign q_a_out    = q_a_s1_q;
        assign q_b_out    = q_b_s1_q;
        assign vld_a_out  = vld_a_s1_q;
        assign vld_b_out  = vld_b_s1_q;
        assign coll_out   = coll_s1_q;
        assign perr_a_out = perr_a_s1_q;
        assign perr_b_out = perr_b_s1_q;
    end

    assign q_a_o       = q_a_out;
    assign q_b_o       = q_b_out;
    assign q_a_valid_o = vld_a_out;
    assign q_b_valid_o = vld_b_out;
    assign collision_o = coll_out;

`ifdef COEF_DPRAM_PARITY_EN
    assign par_err_a_o = perr_a_out;
    assign par_err_b_o = perr_b_out;
`else
    logic unused_perr;
    assign unused_perr = perr_a_out | perr_b_out;
`endif

endmodule

// File: doc/coef_dpram_ctrl.md
Name: coef_dpram_ctrl

Overview:
Parametrised true dual-port coefficient memory for the Kyber NTT datapath. It is the next generation of the 12-bit x 512 coefficient RAM, with these additions:
- selectable read latency and read-during-write mode
- per-port enables and read-valid tracking
- deterministic write-collision arbitration with a flag
- a built-in clear engine that zeroes the array after reset or on request.
It sits between the butterfly/address-generation control and the block RAM.

Parameters:
DATA_W, 12, coefficient width in bits
ADDR_W, 9, address width
DEPTH, 512, number of words; must be <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register)
RDW_MODE, 0, same-port read-during-write: 0 = write-first (q = new data), 1 = read-first (q = old data)
CLEAR_ON_RESET, 1, 1 = clear engine starts automatically when rst deasserts

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
clr_start  in  1  one-cycle request to zero the whole array; sampled only in IDLE
busy  out  1  high while the clear engine runs; port accesses are ignored
en_a  in  1  port A access enable
we_a  in  1  port A write enable; qualified by en_a
addr_a  in  ADDR_W  port A address
data_a  in  DATA_W  port A write data
q_a  out  DATA_W  port A read data
q_a_valid  out  1  q_a carries the result of an access issued RD_LAT cycles earlier
en_b, we_b, addr_b, data_b, q_b, q_b_valid  same as port A, for port B
collision  out  1  pulse: both ports wrote the same address in the same cycle

Behaviour:
- Reset (synchronous, active-high):
  - q_a, q_b, q_a_valid, q_b_valid, collision and the clear counter go to 0.
  - The FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE; busy follows the FSM state.
  - Array contents are not reset by rst itself.
- FSM states:
  - IDLE: normal operation. clr_start=1 moves to CLEAR.
  - CLEAR: each cycle writes 0 to address clr_cnt and increments clr_cnt. After writing DEPTH-1, clr_cnt returns to 0 and the FSM returns to IDLE.
  - Clear duration is exactly DEPTH cycles with busy=1; busy falls the cycle after the last write.
- During CLEAR:
  - en_a and en_b are ignored; no write occurs and q_x_valid stays 0.
  - q_a and q_b hold their values.
  - clr_start is ignored.
- Reset asserted mid-clear aborts it. After release the clear restarts from address 0 (CLEAR_ON_RESET=1) or stays IDLE (CLEAR_ON_RESET=0).
- Port access in IDLE:
  - en_x=1 with we_x=0 reads ram[addr_x].
  - en_x=1 with we_x=1 writes data_x. q_x returns data_x (RDW_MODE=0) or the old content (RDW_MODE=1).
  - en_x=0: no access, q_x holds, q_x_valid=0 at the matching latency slot.
- Latency:
  - RD_LAT=1: q_x and q_x_valid update on the edge after the access.
  - RD_LAT=2: one extra register stage, so fully pipelined throughput is one access per cycle per port.
- Cross-port same address:
  - A writes, B reads the same address in the same cycle: q_b returns the old content.
  - Both ports write the same address in the same cycle: port A's data is stored and port B's write is dropped. collision=1 for one cycle, aligned with q_x_valid. Each port's q follows its own RDW_MODE rule using its own data.
- Addresses >= DEPTH (when DEPTH < 2**ADDR_W): writes are dropped; reads return 0 with valid=1.
- Width rule: data is stored unmodified (DATA_W bits); no modular reduction is performed in this block.

Optional Feature:
COEF_DPRAM_PARITY_EN
- Defined:
  - Each word stores DATA_W+1 bits, with even parity computed on write. The clear engine writes word 0 with parity 0.
  - On read, parity is checked. Outputs par_err_a and par_err_b (1 bit each, reset 0) pulse aligned with q_x_valid on a mismatch.
  - Read data is still delivered unchanged.
- Undefined: no parity storage, no par_err ports; the array is exactly DATA_W bits wide.

Test Plan:
- Reset release, CLEAR_ON_RESET=1, DEPTH=512 -> busy high for exactly 512 cycles, then low. Reading addresses 0, 255 and 511 returns 0x000 with valid after RD_LAT.
- Write A addr 5 = 0xD00, then read B addr 5 next cycle -> q_b = 0xD00, q_b_valid=1 after RD_LAT (checked for RD_LAT=1 and 2).
- Same cycle: A writes 0x123 @10 and B writes 0x456 @10 -> collision pulses once. A later read of @10 returns 0x123.
- Port A write 0x0AB @7 over old 0x011 -> q_a = 0x0AB with RDW_MODE=0 and 0x011 with RDW_MODE=1. Same-cycle B read of @7 returns 0x011.
- clr_start after filling memory, then rst asserted at clear cycle 100 -> clear restarts from address 0 and runs a full 512 cycles. Port writes during busy have no effect.
- With COEF_DPRAM_PARITY_EN: force one bit flip of the stored word @3 via backdoor -> read gives par_err_a=1 for one cycle. Clean words give par_err_a=0.
